// File: rtl/pimc_pkg.sv
// Shared definitions for the PIMC router: table-entry layout, trigger encodings and FSM states.
package pimc_pkg;

  localparam int MASK_BIT = 0;
  localparam int TRIG_BIT = 1;
  localparam int PRIO_LSB = 2;

  localparam int DEF_PRIO_BITS    = 3;
  localparam int DEF_CPU_ID_WIDTH = 8;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  // Entry layout at the default widths; field order matches the bit offsets above.
  typedef struct packed {
    logic [DEF_CPU_ID_WIDTH-1:0] cpu;
    logic [DEF_PRIO_BITS-1:0]    prio;
    logic                        trigger;
    logic                        mask;
  } pimc_ent_t;

  typedef enum logic [1:0] {
    IDLE,
    NOTIFY,
    INSERVICE
  } pimc_state_t;

endpackage

// File: rtl/pimc_arbiter.sv
// Combinational pick of the eligible line with the highest priority; ties resolve to the lowest index.
module pimc_arbiter #(
  parameter int N         = 16,
  parameter int PRIO_BITS = 3,
  parameter int IDX_W     = 4
) (
  input  logic [N-1:0]           elig,
  input  logic [N*PRIO_BITS-1:0] prio,
  output logic                   valid,
  output logic [IDX_W-1:0]       idx
);

  logic [PRIO_BITS-1:0] best;

  // NOTE: blocking assignments are deliberate here: each loop iteration must see the
  // running best from the previous one, and every output gets a default first so no latch forms.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (!valid || prio[i*PRIO_BITS +: PRIO_BITS] > best)) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
        best  = prio[i*PRIO_BITS +: PRIO_BITS];
      end
    end
  end

endmodule

// File: rtl/pimc_router.sv
// Interrupt router: per-line config table, edge latching, priority arbitration and a
// notify/irqack/eoi delivery handshake toward the interrupt fabric.
module pimc_router
  import pimc_pkg::*;
#(
  parameter  int IRQ_PIN_COUNT = 16,
  parameter  int PRIO_BITS     = 3,
  parameter  int CPU_ID_WIDTH  = 8,
  localparam int ENT_W         = 2 + PRIO_BITS + CPU_ID_WIDTH,
  localparam int IDX_W         = (IRQ_PIN_COUNT > 1) ? $clog2(IRQ_PIN_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IRQ_PIN_COUNT-1:0] irq_in,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [ENT_W-1:0]         cfg_wdata,
  output logic [ENT_W-1:0]         cfg_rdata,
  input  logic                     irqack,
  input  logic                     eoi,
  output logic                     notify,
  output logic [7:0]               lineno,
  output logic [CPU_ID_WIDTH-1:0]  processor_id,
  output logic                     busy
);

  localparam int CPU_LSB = PRIO_LSB + PRIO_BITS;
  localparam logic [ENT_W-1:0] RST_ENT = ENT_W'({TRIG_LEVEL, 1'b1});

  logic [ENT_W-1:0]               ent_tbl [IRQ_PIN_COUNT];
  logic [IRQ_PIN_COUNT-1:0]       irq_q, pend, pend_d, mask_v, edge_v, elig;
  logic [IRQ_PIN_COUNT*PRIO_BITS-1:0] prio_v;
  logic                           win_valid;
  logic [IDX_W-1:0]               win_idx;
  logic                           cfg_hit, ack;
  pimc_state_t                    state;

  assign cfg_hit   = {1'b0, cfg_idx} < (IDX_W+1)'(IRQ_PIN_COUNT);
  assign cfg_rdata = cfg_hit ? ent_tbl[cfg_idx] : '0;
  assign ack       = (state == NOTIFY) && irqack;
  assign busy      = (state != IDLE);

  always_comb begin
    mask_v = '0;
    edge_v = '0;
    prio_v = '0;
    elig   = '0;
    pend_d = pend;
    for (int i = 0; i < IRQ_PIN_COUNT; i++) begin
      mask_v[i] = ent_tbl[i][MASK_BIT];
      edge_v[i] = (ent_tbl[i][TRIG_BIT] == TRIG_EDGE);
      prio_v[i*PRIO_BITS +: PRIO_BITS] = ent_tbl[i][PRIO_LSB +: PRIO_BITS];
      elig[i]   = ~mask_v[i] & (edge_v[i] ? pend[i] : irq_in[i]);
      // A fresh rise on the line being acknowledged wins over the ack clear.
      if (ack && lineno == 8'(i))
        pend_d[i] = 1'b0;
      if (irq_in[i] && !irq_q[i] && !mask_v[i] && edge_v[i])
        pend_d[i] = 1'b1;
    end
  end

  pimc_arbiter #(
    .N        (IRQ_PIN_COUNT),
    .PRIO_BITS(PRIO_BITS),
    .IDX_W    (IDX_W)
  ) u_arbiter (
    .elig (elig),
    .prio (prio_v),
    .valid(win_valid),
    .idx  (win_idx)
  );

  // NOTE: the table is a small flop array, not a RAM; it is reset so every line powers up masked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IRQ_PIN_COUNT; i++)
        ent_tbl[i] <= RST_ENT;
    end else if (cfg_we && cfg_hit) begin
      ent_tbl[cfg_idx] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= irq_in;
      pend  <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      notify       <= 1'b0;
      lineno       <= '0;
      processor_id <= '0;
    end else begin
      case (state)
        IDLE: if (win_valid) begin
          lineno       <= 8'(win_idx);
          processor_id <= ent_tbl[win_idx][CPU_LSB +: CPU_ID_WIDTH];
          notify       <= 1'b1;
          state        <= NOTIFY;
        end
        NOTIFY: if (irqack) begin
          notify <= 1'b0;
          state  <= INSERVICE;
        end
        INSERVICE: if (eoi) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pimc_router.sv
// Scoreboard bench for pimc_router: expected deliveries are queued as stimulus is driven
// and compared when notify rises.
module tb_pimc_router;
  import pimc_pkg::*;

  localparam int N  = 16;
  localparam int CW = 8;
  localparam int EW = 13;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [EW-1:0] cfg_wdata, cfg_rdata;
  logic          irqack, eoi, notify, busy;
  logic [7:0]    lineno;
  logic [CW-1:0] processor_id;

  typedef struct {
    logic [7:0] line;
    logic [7:0] cpu;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  int   bad;

  pimc_router dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irqack(irqack), .eoi(eoi),
    .notify(notify), .lineno(lineno), .processor_id(processor_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ent(logic m, logic t, logic [2:0] p, logic [7:0] c);
    pimc_ent_t x;
    x.mask = m; x.trigger = t; x.prio = p; x.cpu = c;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [EW-1:0] val);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_wdata = val;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input int line);
    irq_in[line] = 1'b1;
    tick();
    irq_in[line] = 1'b0;
  endtask

  task automatic do_ack();
    irqack = 1'b1; tick(); irqack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  // Waits (bounded) for notify; returns the number of clock edges that elapsed.
  task automatic wait_notify(output int c);
    c = 0;
    while (notify !== 1'b1 && c < 8) begin
      tick();
      c++;
    end
  endtask

  task automatic quiet_cycles(input int n, output int viol);
    viol = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (notify !== 1'b0) viol++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
    irqack = 1'b0; eoi = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({notify, busy, lineno, processor_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: notify=%b busy=%b lineno=%0d pid=%0d, want all 0",
               notify, busy, lineno, processor_id);
    end
    cfg_idx = 4'd3; #1;
    checks++;
    if (cfg_rdata !== ent(1'b1, TRIG_LEVEL, 3'd0, 8'd0)) begin
      errors++;
      $display("FAIL reset_table: got %h want %h", cfg_rdata, ent(1'b1, TRIG_LEVEL, 3'd0, 8'd0));
    end
  endtask

  task automatic test_level();
    cfg_write(3, ent(1'b0, TRIG_LEVEL, 3'd2, 8'd5));
    checks++;
    if (cfg_rdata !== ent(1'b0, TRIG_LEVEL, 3'd2, 8'd5)) begin
      errors++; $display("FAIL cfg_readback: got %h", cfg_rdata);
    end
    sb.push_back('{8'd3, 8'd5, 1});
    irq_in[3] = 1'b1;
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat) begin errors++; $display("FAIL level_latency: got %0d want %0d", cyc, e.lat); end
    checks++;
    if ({lineno, processor_id} !== {e.line, e.cpu}) begin
      errors++; $display("FAIL level_line: got %0d/%0d want %0d/%0d", lineno, processor_id, e.line, e.cpu);
    end
    repeat (2) tick();
    checks++;
    if (notify !== 1'b1 || lineno !== 8'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL level_hold: notify=%b lineno=%0d busy=%b want 1/3/1", notify, lineno, busy);
    end
    do_ack();
    checks++;
    if (notify !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL level_ack: notify=%b busy=%b want 0/1", notify, busy);
    end
    do_eoi();
    checks++;
    if (notify !== 1'b0) begin errors++; $display("FAIL level_eoi_idle: notify=%b want 0", notify); end
    sb.push_back('{8'd3, 8'd5, 1});
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat || lineno !== e.line || processor_id !== e.cpu) begin
      errors++; $display("FAIL level_redeliver: cyc=%0d line=%0d pid=%0d want %0d/%0d/%0d",
                         cyc, lineno, processor_id, e.lat, e.line, e.cpu);
    end
    do_ack(); irq_in[3] = 1'b0; do_eoi();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL level_done: busy=%b want 0", busy); end
  endtask

  task automatic test_edge();
    cfg_write(7, ent(1'b0, TRIG_EDGE, 3'd1, 8'h17));
    sb.push_back('{8'd7, 8'h17, 1});
    pulse(7);
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat || lineno !== e.line || processor_id !== e.cpu) begin
      errors++; $display("FAIL edge_deliver: cyc=%0d line=%0d pid=%h want %0d/%0d/%h",
                         cyc, lineno, processor_id, e.lat, e.line, e.cpu);
    end
    do_ack(); do_eoi();
    quiet_cycles(5, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL edge_no_redeliver: notify high %0d cycles, want 0", bad); end
    checks++;
    if (lineno !== 8'd7 || processor_id !== 8'h17) begin
      errors++; $display("FAIL edge_hold_regs: got %0d/%h want 7/17", lineno, processor_id);
    end
  endtask

  task automatic test_tie();
    cfg_write(2, ent(1'b0, TRIG_LEVEL, 3'd4, 8'h22));
    cfg_write(9, ent(1'b0, TRIG_LEVEL, 3'd4, 8'h99));
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        cfg_write(9, ent(1'b0, TRIG_LEVEL, 3'd6, 8'h99));
        sb.push_back('{8'd9, 8'h99, 1});
      end else begin
        sb.push_back('{8'd2, 8'h22, 1});
      end
      irq_in[2] = 1'b1; irq_in[9] = 1'b1;
      wait_notify(cyc); e = sb.pop_front();
      checks++;
      if (cyc != e.lat || lineno !== e.line || processor_id !== e.cpu) begin
        errors++; $display("FAIL tie_pass%0d: cyc=%0d line=%0d pid=%h want %0d/%0d/%h",
                           pass, cyc, lineno, processor_id, e.lat, e.line, e.cpu);
      end
      do_ack(); irq_in[2] = 1'b0; irq_in[9] = 1'b0; do_eoi();
    end
  endtask

  task automatic test_mask();
    cfg_write(4, ent(1'b1, TRIG_EDGE, 3'd3, 8'h44));
    pulse(4);
    cfg_write(4, ent(1'b0, TRIG_EDGE, 3'd3, 8'h44));
    quiet_cycles(4, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mask_drop: notify high %0d cycles, want 0", bad); end
    sb.push_back('{8'd4, 8'h44, 1});
    pulse(4);
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat || lineno !== e.line || processor_id !== e.cpu) begin
      errors++; $display("FAIL mask_deliver: cyc=%0d line=%0d pid=%h want %0d/%0d/%h",
                         cyc, lineno, processor_id, e.lat, e.line, e.cpu);
    end
    cfg_write(4, ent(1'b1, TRIG_EDGE, 3'd3, 8'h44));
    checks++;
    if (notify !== 1'b1 || lineno !== 8'd4) begin
      errors++; $display("FAIL mask_no_retract: notify=%b lineno=%0d want 1/4", notify, lineno);
    end
    do_ack();
    checks++;
    if (notify !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mask_ack: notify=%b busy=%b want 0/1", notify, busy);
    end
    do_eoi();
  endtask

  task automatic test_back_to_back();
    cfg_write(1, ent(1'b0, TRIG_EDGE, 3'd5, 8'h11));
    sb.push_back('{8'd1, 8'h11, 1});
    pulse(1);
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat || lineno !== e.line) begin
      errors++; $display("FAIL b2b_first: cyc=%0d line=%0d want %0d/%0d", cyc, lineno, e.lat, e.line);
    end
    irq_in[1] = 1'b1; irqack = 1'b1; eoi = 1'b1;
    tick();
    irq_in[1] = 1'b0; irqack = 1'b0; eoi = 1'b0;
    checks++;
    if (notify !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_ack_eoi: notify=%b busy=%b want 0/1", notify, busy);
    end
    quiet_cycles(2, bad);
    checks++;
    if (bad != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_inservice: notify cycles=%0d busy=%b want 0/1", bad, busy);
    end
    do_eoi();
    sb.push_back('{8'd1, 8'h11, 1});
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat || lineno !== e.line || processor_id !== e.cpu) begin
      errors++; $display("FAIL b2b_rearm: cyc=%0d line=%0d pid=%h want %0d/%0d/%h",
                         cyc, lineno, processor_id, e.lat, e.line, e.cpu);
    end
    do_ack(); do_eoi();
    eoi = 1'b1; irqack = 1'b1;
    tick();
    eoi = 1'b0; irqack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || notify !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: busy=%b notify=%b want 0/0", busy, notify);
    end
  endtask

  task automatic test_reset_mid();
    sb.push_back('{8'd3, 8'd5, 1});
    irq_in[3] = 1'b1;
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat || lineno !== e.line || processor_id !== e.cpu) begin
      errors++; $display("FAIL rstmid_pre: cyc=%0d line=%0d pid=%0d want %0d/%0d/%0d",
                         cyc, lineno, processor_id, e.lat, e.line, e.cpu);
    end
    #2 rst = 1'b1;
    cfg_idx = 4'd3;
    #1;
    checks++;
    if ({notify, busy, lineno, processor_id} !== '0) begin
      errors++; $display("FAIL rstmid_async: notify=%b busy=%b lineno=%0d pid=%0d want 0",
                         notify, busy, lineno, processor_id);
    end
    checks++;
    if (cfg_rdata !== ent(1'b1, TRIG_LEVEL, 3'd0, 8'd0)) begin
      errors++; $display("FAIL rstmid_table: got %h", cfg_rdata);
    end
    tick();
    rst = 1'b0;
    irq_in = '1;
    quiet_cycles(4, bad);
    irq_in = '0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_masked: notify high %0d cycles, want 0", bad); end
    cfg_write(3, ent(1'b0, TRIG_LEVEL, 3'd2, 8'd5));
    sb.push_back('{8'd3, 8'd5, 1});
    irq_in[3] = 1'b1;
    wait_notify(cyc); e = sb.pop_front();
    checks++;
    if (cyc != e.lat || lineno !== e.line || processor_id !== e.cpu) begin
      errors++; $display("FAIL rstmid_reconfig: cyc=%0d line=%0d pid=%0d want %0d/%0d/%0d",
                         cyc, lineno, processor_id, e.lat, e.line, e.cpu);
    end
    do_ack(); irq_in[3] = 1'b0; do_eoi();
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_tie();
    test_mask();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pimc_router.md
Name: pimc_router

Overview:
Second-generation Platform Interrupt Message Controller. It routes up to IRQ_PIN_COUNT interrupt lines to a target processor ID. Each line has a software-programmable table entry holding mask, trigger mode, priority and target CPU. Pending edge interrupts are latched, the highest-priority eligible line is arbitrated, and delivery runs through a notify/irqack/eoi handshake with the interrupt fabric above it.

Parameters:
IRQ_PIN_COUNT, 16, number of interrupt input lines (1..256)
PRIO_BITS, 3, width of the per-line priority field
CPU_ID_WIDTH, 8, width of the target processor ID
ENT_W, 2+PRIO_BITS+CPU_ID_WIDTH, derived table-entry width (not overridden)
IDX_W, $clog2(IRQ_PIN_COUNT) (min 1), derived line-index width

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
irq_in  in  IRQ_PIN_COUNT  raw interrupt lines, active-high, synchronous to clk
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  table entry index for write and read
cfg_wdata  in  ENT_W  entry: [0]=mask, [1]=trigger (0 level, 1 edge), [2+:PRIO_BITS]=priority, [2+PRIO_BITS+:CPU_ID_WIDTH]=cpu id
cfg_rdata  out  ENT_W  combinational read of table[cfg_idx]
irqack  in  1  core accepts the notified interrupt
eoi  in  1  core signals end of interrupt
notify  out  1  interrupt presented (lineno/processor_id valid)
lineno  out  8  delivered line number, zero-extended
processor_id  out  CPU_ID_WIDTH  target CPU of the delivered line
busy  out  1  high in the NOTIFY or INSERVICE state

Behaviour:
- Reset (async assert, sync release):
  - notify=0, lineno=0, processor_id=0, busy=0, state=IDLE.
  - All table entries = mask 1, level, prio 0, cpu 0.
  - Edge-pending vector and irq_q cleared.
- Configuration: cfg_we writes table[cfg_idx] at the posedge. The new value is used by the arbiter from the next cycle. cfg_idx >= IRQ_PIN_COUNT: write ignored, cfg_rdata=0.
- Edge detect: irq_q <= irq_in every cycle. rise[i] = irq_in[i] & ~irq_q[i].
  - An unmasked edge line with rise sets pend[i] at that posedge.
  - Rises on masked lines are dropped, not latched.
  - Unmasking does not clear pend; masking leaves pend held but makes the line ineligible.
- Eligibility: elig[i] = ~mask[i] & (trigger[i] ? pend[i] : irq_in[i]).
- Arbitration (combinational): highest priority value wins; ties go to the lowest index.
- FSM states are IDLE, NOTIFY and INSERVICE.
  - IDLE: if any elig is set at a posedge, register the winner's lineno and processor_id, set notify<=1, go to NOTIFY.
  - NOTIFY: notify held with lineno/processor_id stable until irqack=1. At that posedge notify<=0, pend[lineno] is cleared, and the FSM goes to INSERVICE.
  - NOTIFY: no retraction. Masking, reconfiguring or deasserting the line does not withdraw the delivery.
  - INSERVICE: eoi=1 at a posedge returns the FSM to IDLE. lineno/processor_id keep their last values.
- Latency:
  - Level line asserted before posedge k: notify=1 after posedge k.
  - Edge rising sampled at posedge k: pend set at k, notify=1 after posedge k+1.
  - After eoi, the next eligible line is notified one cycle later, with no dead cycle beyond IDLE.
- Ignored inputs: irqack outside NOTIFY, and eoi outside INSERVICE.
- irqack and eoi together in NOTIFY: only irqack takes effect.
- A rise on the delivered line in the same cycle as its ack-clear: the set wins, and the line stays pending.
- A level line still asserted after eoi is re-delivered.
- Reset mid-operation: immediate return to reset values. Any in-flight delivery is lost.

Decomposition:
- Package pimc_pkg holds:
  - the entry bit-offset constants and a packed pimc_ent_t struct (mask, trigger, prio, cpu);
  - the state enum pimc_state_t {IDLE, NOTIFY, INSERVICE};
  - the trigger constants TRIG_LEVEL and TRIG_EDGE.
- Sub-module pimc_arbiter: combinational priority/index pick from elig plus the priority vector. Outputs are valid and winner index.

Test Plan:
- Reset, write line 3 = {unmask, level, prio 2, cpu 5}, hold irq_in[3]=1 -> notify=1 one cycle later, lineno=3, processor_id=5; irqack -> notify=0; eoi while irq_in[3] still 1 -> redelivered.
- Line 7 edge, prio 1: pulse irq_in[7] for one cycle -> notify after 2 cycles, lineno=7; irqack clears pend; eoi -> no redelivery.
- Lines 2 and 9 level, both prio 4, asserted together -> lineno=2. Set line 9 to prio 6 and repeat -> lineno=9.
- Line 4 masked, edge pulse, then unmask -> no notify. Unmask first, pulse, then mask during NOTIFY -> delivery completes with lineno=4.
- Edge line 1 re-pulsed in the irqack cycle -> after eoi, line 1 is notified again. eoi or irqack issued in IDLE -> no state change.
- Assert rst during NOTIFY -> notify=0, lineno=0, all lines masked; stimulus on irq_in produces no notify until reconfigured.
